sr_ff_driver: RTL and testbench



---
 rtl/sr_ff_driver.sv | 133 +++++++++++++
 tb/tb_sr_ff_driver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_driver.sv
// sr_ff_driver: set/reset command sequencer for a gated SR flip-flop.
// Emits one fixed-width s or r pulse per request, then verifies q/qbar.
module sr_ff_driver #(
  parameter int unsigned PW = 2,
  parameter int unsigned DT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_op,
  output logic req_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  input  logic qbar_fb,
  output logic busy,
  output logic exp_q,
  output logic err
);

  if (PW < 1 || PW > 15) begin : g_bad_pw
    $error("sr_ff_driver: PW must be 1..15");
  end
  if (DT > 15) begin : g_bad_dt
    $error("sr_ff_driver: DT must be 0..15");
  end

  localparam logic [3:0] PW1 = 4'(PW - 1);
  localparam logic [3:0] DT1 = 4'(DT - 1);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    DEAD,
    CHECK
  } state_t;

  state_t     st;
  state_t     st_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic       op;
  logic       op_n;
  logic       chk;
  logic       accept;
  logic       q_s1;
  logic       q_s2;
  logic       qb_s1;
  logic       qb_s2;
  logic       mis;

  assign req_ready = (st == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign busy      = (st != IDLE);
  // q == qbar always counts as a mismatch
  assign mis       = (q_s2 != op) || (qb_s2 != ~op);

  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    op_n  = op;
    chk   = 1'b0;
    unique case (st)
      IDLE: begin
        if (accept) begin
          st_n  = PULSE;
          cnt_n = PW1;
          op_n  = req_op;
        end
      end
      PULSE: begin
        if (cnt == 4'd0) begin
          if (DT == 0) begin
            st_n  = CHECK;
            cnt_n = 4'd1;
          end else begin
            st_n  = DEAD;
            cnt_n = DT1;
          end
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      DEAD: begin
        if (cnt == 4'd0) begin
          st_n  = CHECK;
          cnt_n = 4'd1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      CHECK: begin
        if (cnt == 4'd0) begin
          st_n = IDLE;
          chk  = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      cnt   <= 4'd0;
      op    <= 1'b0;
      s     <= 1'b0;
      r     <= 1'b0;
      exp_q <= 1'b0;
      err   <= 1'b0;
      q_s1  <= 1'b0;
      q_s2  <= 1'b0;
      qb_s1 <= 1'b0;
      qb_s2 <= 1'b0;
    end else begin
      st    <= st_n;
      cnt   <= cnt_n;
      op    <= op_n;
      // drives decoded from next state so s and r are glitch-free flops
      s     <= (st_n == PULSE) && op_n;
      r     <= (st_n == PULSE) && !op_n;
      if (accept) exp_q <= req_op;
      if (chk && mis) err <= 1'b1;
      q_s1  <= q_fb;
      q_s2  <= q_s1;
      qb_s1 <= qbar_fb;
      qb_s2 <= qb_s1;
    end
  end

endmodule

// File: tb/tb_sr_ff_driver.sv
// tb_sr_ff_driver: randomized and directed checks of sr_ff_driver
// against a timeline model counted in edges since each accept.
module tb_sr_ff_driver;
  localparam int PW = 2;
  localparam int DT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid, req_op, req_ready;
  logic s, r, busy, exp_q, err;
  logic q_fb, qbar_fb;
  logic v1, op1, ready1, s1, r1, busy1, exp1, err1;
  logic q1, qb1;

  int tests = 0;
  int fails = 0;

  bit   active = 0;
  int   k = 0;
  logic mop = 0;
  logic mexp = 0;
  logic merr = 0;

  always #5 clk = ~clk;

  sr_ff_driver #(.PW(PW), .DT(DT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op),
    .req_ready(req_ready), .s(s), .r(r),
    .q_fb(q_fb), .qbar_fb(qbar_fb),
    .busy(busy), .exp_q(exp_q), .err(err)
  );

  sr_ff_driver #(.PW(1), .DT(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(v1), .req_op(op1),
    .req_ready(ready1), .s(s1), .r(r1),
    .q_fb(q1), .qbar_fb(qb1),
    .busy(busy1), .exp_q(exp1), .err(err1)
  );

  // fbm: 0 good feedback, 1 random faults, 2 q stuck high
  task automatic step(input logic v, input logic op, input int fbm);
    bit   acc;
    logic es, er;
    logic [1:0] rb;
    @(negedge clk);
    req_valid = v;
    req_op    = op;
    acc = v && !active;
    @(posedge clk);
    if (acc) begin
      active = 1; k = 0; mop = op; mexp = op;
    end else if (active) begin
      k++;
      if (k == PW + DT + 2) begin
        if (fq_bad()) merr = 1;
        active = 0;
      end
    end
    #1;
    if (acc) begin
      q_fb = mop; qbar_fb = !mop;
      if (fbm == 2) begin
        q_fb = 1; qbar_fb = 0;
      end else if (fbm == 1 && $urandom_range(3) == 0) begin
        rb = 2'($urandom);
        q_fb = rb[1]; qbar_fb = rb[0];
      end
    end
    es = active && k < PW && mop;
    er = active && k < PW && !mop;
    tests++;
    if (s !== es) begin
      fails++; $display("FAIL s: got %b want %b k=%0d", s, es, k);
    end
    tests++;
    if (r !== er) begin
      fails++; $display("FAIL r: got %b want %b k=%0d", r, er, k);
    end
    tests++;
    if (req_ready !== !active) begin
      fails++; $display("FAIL ready: got %b want %b", req_ready, !active);
    end
    tests++;
    if (busy !== active) begin
      fails++; $display("FAIL busy: got %b want %b", busy, active);
    end
    tests++;
    if (exp_q !== mexp) begin
      fails++; $display("FAIL exp_q: got %b want %b", exp_q, mexp);
    end
    tests++;
    if (err !== merr) begin
      fails++; $display("FAIL err: got %b want %b", err, merr);
    end
  endtask

  function automatic bit fq_bad();
    return (q_fb !== mop) || (qbar_fb !== !mop);
  endfunction

  task automatic test_reset();
    rst_n = 0; req_valid = 1; req_op = 1;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (s !== 0 || r !== 0) begin
      fails++; $display("FAIL rst_sr: got %b%b want 00", s, r);
    end
    tests++;
    if (req_ready !== 0) begin
      fails++; $display("FAIL rst_ready: got %b want 0", req_ready);
    end
    tests++;
    if (busy !== 0) begin
      fails++; $display("FAIL rst_busy: got %b want 0", busy);
    end
    tests++;
    if (exp_q !== 0 || err !== 0) begin
      fails++; $display("FAIL rst_exp_err: got %b%b want 00", exp_q, err);
    end
    @(negedge clk);
    req_valid = 0;
    rst_n = 1;
    step(0, 0, 0);
  endtask

  task automatic test_set();
    step(1, 1, 0);
    repeat (6) step(0, 0, 0);
  endtask

  task automatic test_stuck_fb();
    step(1, 0, 2);
    repeat (5) step(0, 0, 0);
    tests++;
    if (err !== 1) begin
      fails++; $display("FAIL stuck_err: got %b want 1", err);
    end
    step(1, 1, 0);
    repeat (5) step(0, 0, 0);
    step(1, 0, 0);
    repeat (5) step(0, 0, 0);
  endtask

  task automatic test_toggle();
    logic t = 0;
    repeat (30) begin
      step(1, t, 0);
      t = !t;
    end
    repeat (6) step(0, 0, 0);
  endtask

  task automatic test_random();
    repeat (300)
      step(1'($urandom_range(1)), 1'($urandom_range(1)), 1);
    repeat (6) step(0, 0, 0);
  endtask

  task automatic test_midpulse_reset();
    step(1, 1, 0);
    #2;
    rst_n = 0;
    #1;
    tests++;
    if (s !== 0 || r !== 0) begin
      fails++; $display("FAIL mid_rst_sr: got %b%b want 00", s, r);
    end
    tests++;
    if (busy !== 0 || req_ready !== 0) begin
      fails++; $display("FAIL mid_rst_bsy_rdy: got %b%b want 00", busy, req_ready);
    end
    tests++;
    if (err !== 0 || exp_q !== 0) begin
      fails++; $display("FAIL mid_rst_err_exp: got %b%b want 00", err, exp_q);
    end
    active = 0; merr = 0; mexp = 0;
    req_valid = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (6) step(0, 0, 0);
  endtask

  task automatic test_pw1_dt0();
    @(negedge clk);
    v1 = 1; op1 = 1;
    @(posedge clk); #1;
    tests++;
    if (s1 !== 1 || r1 !== 0 || busy1 !== 1) begin
      fails++; $display("FAIL pw1_k0: got s%b r%b b%b want s1 r0 b1", s1, r1, busy1);
    end
    v1 = 0;
    @(posedge clk); #1;
    tests++;
    if (s1 !== 0 || busy1 !== 1) begin
      fails++; $display("FAIL pw1_k1: got s%b b%b want s0 b1", s1, busy1);
    end
    @(posedge clk); #1;
    tests++;
    if (ready1 !== 0) begin
      fails++; $display("FAIL pw1_k2: got ready %b want 0", ready1);
    end
    @(posedge clk); #1;
    tests++;
    if (ready1 !== 1 || busy1 !== 0) begin
      fails++; $display("FAIL pw1_k3: got rdy%b b%b want rdy1 b0", ready1, busy1);
    end
    tests++;
    if (exp1 !== 1 || err1 !== 0) begin
      fails++; $display("FAIL pw1_exp_err: got %b%b want 10", exp1, err1);
    end
  endtask

  initial begin
    req_valid = 0; req_op = 0;
    q_fb = 0; qbar_fb = 1;
    v1 = 0; op1 = 0; q1 = 1; qb1 = 0;
    test_reset();
    test_set();
    test_stuck_fb();
    test_toggle();
    test_random();
    test_midpulse_reset();
    test_pw1_dt0();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
